// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with whole-scan debouncing.
// One column is driven low at a time. The four row lines are sampled at the end
// of each column dwell into a 16-bit snapshot. A small FSM looks at every
// completed scan and accepts a single key press, or releases it, only after
// DEBOUNCE_SCANS consecutive qualifying scans.
module keypad_scanner #(
    parameter int SCAN_DIV       = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [SCAN_DIV-1:0] PRESC_ONE = SCAN_DIV'(1);
    localparam logic [3:0]          DEB_TARGET = 4'(DEBOUNCE_SCANS);

    // Snapshot index is col*4+row, while key codes are row*4+col. The two
    // 2-bit fields simply swap places, so one helper converts both ways.
    function automatic logic [3:0] swap_fields(input logic [3:0] value);
        return {value[1:0], value[3:2]};
    endfunction

    logic [3:0]          row_meta;
    logic [3:0]          row_sync;
    logic [SCAN_DIV-1:0] presc;
    logic [1:0]          col_idx;
    logic [15:0]         snapshot;
    state_t              state;
    logic [3:0]          cand;
    logic [3:0]          cnt;

    logic                tick;
    logic                scan_done;
    logic [15:0]         snap_next;
    logic [4:0]          hit_count;
    logic [3:0]          hit_idx;
    logic [3:0]          hit_key;
    logic                is_single;
    logic                held_bit;
    logic [3:0]          cnt_inc;

    assign tick      = &presc;
    assign scan_done = tick && (col_idx == 2'd3);
    assign cnt_inc   = cnt + 4'd1;

    // Two-flop synchroniser: row lines are asynchronous to clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Free-running column-dwell prescaler; it wraps to zero after all ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_ONE;
        end
    end

    // Column sequencing and per-column row capture at the end of each dwell.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_idx  <= 2'd0;
            col      <= 4'b1110;
            snapshot <= 16'd0;
        end else if (tick) begin
            col_idx  <= col_idx + 2'd1;
            col      <= ~(4'b0001 << (col_idx + 2'd1));
            snapshot <= snap_next;
        end else begin
            col_idx  <= col_idx;
            col      <= col;
            snapshot <= snapshot;
        end
    end

    // Completed snapshot including the column sampled this cycle, plus its classification.
    always_comb begin
        snap_next = snapshot;
        if (tick) begin
            snap_next[{col_idx, 2'b00} +: 4] = ~row_sync;
        end else begin
            snap_next = snapshot;
        end

        hit_count = 5'd0;
        hit_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_next[i]) begin
                hit_count = hit_count + 5'd1;
                hit_idx   = i[3:0];
            end else begin
                hit_count = hit_count;
            end
        end

        is_single = (hit_count == 5'd1);
        hit_key   = swap_fields(hit_idx);
        held_bit  = snap_next[swap_fields(key_code)];
    end

    // Debounce FSM; evaluated once per completed scan, outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand  <= hit_key;
                            cnt   <= 4'd1;
                            state <= PRESS_WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (is_single && (hit_key == cand)) begin
                            if (cnt_inc == DEB_TARGET) begin
                                state     <= HELD;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= 4'd0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else if (is_single) begin
                            cand <= hit_key;
                            cnt  <= 4'd1;
                        end else begin
                            cnt   <= 4'd0;
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        // Extra keys are ignored while the accepted key stays down.
                        if (held_bit) begin
                            state <= HELD;
                        end else begin
                            cnt   <= 4'd1;
                            state <= RELEASE_WAIT;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!held_bit) begin
                            if (cnt_inc == DEB_TARGET) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                                cnt      <= 4'd0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            // Bounce during release: back to held, no new strobe.
                            cnt   <= 4'd0;
                            state <= HELD;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= 4'd0;
                        key_held <= 1'b0;
                    end
                endcase
            end else begin
                state <= state;
            end
        end
    end

endmodule
